// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: mode encoding and
// slicing helpers used to size and validate the pipeline.
package adder_pkg;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

   function automatic int unsigned slice_width(int unsigned width, int unsigned stages);
      return width / stages;
   endfunction

   function automatic bit slicing_ok(int unsigned width, int unsigned stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result stream bundle for pipelined_adder: input handshake with
// operands and mode, output handshake with sum and flags.
interface pipelined_adder_if #(
   parameter int unsigned WIDTH = 64
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

endinterface

// File: rtl/adder_slice.sv
// SLICE-bit combinational ripple-carry chain of full_adder cells; also exposes
// the carry into the MSB so the top slice can derive signed overflow.
module adder_slice #(
   parameter int unsigned SLICE = 16
) (
   input  logic [SLICE-1:0] a_i,
   input  logic [SLICE-1:0] b_i,
   input  logic             c_i,
   output logic [SLICE-1:0] sum_o,
   output logic             cout_o,
   output logic             cmsb_o
);

   // Each bit owns its carry nets so the ripple is not a loop on one vector.
   for (genvar i = 0; i < SLICE; i++) begin : g_bit
      logic ci;
      logic co;

      if (i == 0) begin : g_lsb
         assign ci = c_i;
      end else begin : g_up
         assign ci = g_bit[i-1].co;
      end

      full_adder u_fa (
         .a_i (a_i[i]),
         .b_i (b_i[i]),
         .c_i (ci),
         .s_o (sum_o[i]),
         .c_o (co)
      );
   end

   assign cout_o = g_bit[SLICE-1].co;
   assign cmsb_o = g_bit[SLICE-1].ci;

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor: STAGES registered ripple slices
// behind a valid/ready stream, one result per clock, latency STAGES.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned STAGES = 4
) (
   input  logic                clk,
   input  logic                rst,
   pipelined_adder_if.slave    bus
);

   localparam int unsigned SLICE = slice_width(WIDTH, STAGES);

   if (!slicing_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
   end

   logic [WIDTH-1:0] sum_q [STAGES];
   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] b_q   [STAGES];
   logic             c_q   [STAGES];
   logic             ovf_q [STAGES];
   logic             v_q   [STAGES];

   logic [STAGES-1:0] adv;
   logic              tail_full;

   // adv[k] = !v[k] || adv[k+1] unrolled: a stage advances unless it and every
   // stage after it are occupied while the output is stalled.
   always_comb begin
      tail_full = 1'b1;
      adv       = '0;
      for (int unsigned j = 0; j < STAGES; j++) begin
         tail_full             = tail_full & v_q[STAGES-1-j];
         adv[STAGES-1-j]       = bus.out_ready | ~tail_full;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] a_up;
      logic [WIDTH-1:0] b_up;
      logic [WIDTH-1:0] sum_up;
      logic [WIDTH-1:0] sum_d;
      logic             c_up;
      logic             v_up;
      logic [SLICE-1:0] s_sum;
      logic             s_co;
      logic             s_cm;

      if (k == 0) begin : g_head
         // Mode is folded into the operands here; later stages only add.
         always_comb begin
            a_up   = bus.a;
            b_up   = (mode_e'(bus.sub) == MODE_SUB) ? ~bus.b   : bus.b;
            c_up   = (mode_e'(bus.sub) == MODE_SUB) ? ~bus.cin : bus.cin;
            sum_up = '0;
            v_up   = bus.in_valid;
         end
      end else begin : g_body
         always_comb begin
            a_up   = a_q[k-1];
            b_up   = b_q[k-1];
            c_up   = c_q[k-1];
            sum_up = sum_q[k-1];
            v_up   = v_q[k-1];
         end
      end

      adder_slice #(
         .SLICE (SLICE)
      ) u_slice (
         .a_i    (a_up[k*SLICE +: SLICE]),
         .b_i    (b_up[k*SLICE +: SLICE]),
         .c_i    (c_up),
         .sum_o  (s_sum),
         .cout_o (s_co),
         .cmsb_o (s_cm)
      );

      always_comb begin
         sum_d                    = sum_up;
         sum_d[k*SLICE +: SLICE]  = s_sum;
      end

      // Stalled stages keep everything; bubbles only clear the valid bit.
      always_ff @(posedge clk) begin
         if (rst) begin
            v_q[k]   <= 1'b0;
            sum_q[k] <= '0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            c_q[k]   <= 1'b0;
            ovf_q[k] <= 1'b0;
         end else if (adv[k]) begin
            v_q[k] <= v_up;
            if (v_up) begin
               sum_q[k] <= sum_d;
               a_q[k]   <= a_up;
               b_q[k]   <= b_up;
               c_q[k]   <= s_co;
               ovf_q[k] <= s_cm ^ s_co;
            end
         end
      end
   end

   assign bus.in_ready  = adv[0];
   assign bus.out_valid = v_q[STAGES-1];
   assign bus.sum       = sum_q[STAGES-1];
   assign bus.cout      = c_q[STAGES-1];
   assign bus.ovf       = ovf_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder at 64/4, 8/1 and 32/8 driven from
// one shared stimulus stream, each with its own scoreboard.
module tb_pipelined_adder;
   import adder_pkg::*;

   typedef struct packed {
      logic [63:0] s;
      logic        c;
      logic        o;
   } res_t;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic        sub;
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   localparam int unsigned NDUT = 3;
   localparam int unsigned WID [NDUT] = '{64, 8, 32};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [63:0] d_a, d_b;
   logic        d_cin, d_sub, d_iv, d_or;

   pipelined_adder_if #(.WIDTH(64)) if64 ();
   pipelined_adder_if #(.WIDTH(8))  if8  ();
   pipelined_adder_if #(.WIDTH(32)) if32 ();

   assign {if64.in_valid, if64.a, if64.b, if64.cin, if64.sub, if64.out_ready} = {d_iv, d_a, d_b, d_cin, d_sub, d_or};
   assign {if8.in_valid, if8.a, if8.b, if8.cin, if8.sub, if8.out_ready} = {d_iv, d_a[7:0], d_b[7:0], d_cin, d_sub, d_or};
   assign {if32.in_valid, if32.a, if32.b, if32.cin, if32.sub, if32.out_ready} = {d_iv, d_a[31:0], d_b[31:0], d_cin, d_sub, d_or};

   pipelined_adder #(.WIDTH(64), .STAGES(4)) u_dut64 (.clk(clk), .rst(rst), .bus(if64.slave));
   pipelined_adder #(.WIDTH(8),  .STAGES(1)) u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
   pipelined_adder #(.WIDTH(32), .STAGES(8)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

   int   checks   = 0;
   int   failures = 0;
   int   acc  [NDUT];
   int   emit [NDUT];
   logic hold [NDUT];
   res_t held [NDUT];
   res_t sb   [NDUT][$];

   logic        gv  [NDUT];
   logic        gir [NDUT];
   logic [63:0] gs  [NDUT];
   logic        gc  [NDUT];
   logic        go  [NDUT];

   // Arithmetic reference: integer add/subtract, carry and range test.
   function automatic res_t model(input int unsigned w, input logic [63:0] a_in, input logic [63:0] b_in,
                                  input logic ci, input logic sm);
      logic [63:0]        mask, a, b;
      logic [65:0]        ua, ub, r, c66;
      logic signed [65:0] sa, sbs, sr, maxv, minv;
      res_t               res;
      mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      a    = a_in & mask;
      b    = b_in & mask;
      ua   = {2'b00, a};
      ub   = {2'b00, b};
      c66  = {65'd0, ci};
      sa   = a[w-1] ? $signed(ua - (66'd1 << w)) : $signed(ua);
      sbs  = b[w-1] ? $signed(ub - (66'd1 << w)) : $signed(ub);
      maxv = $signed((66'd1 << (w-1)) - 66'd1);
      minv = -$signed(66'd1 << (w-1));
      if (!sm) begin
         r     = ua + ub + c66;
         res.c = r[w];
         sr    = sa + sbs + $signed(c66);
      end else begin
         r     = ua - ub - c66;
         res.c = (ua >= ub + c66);
         sr    = sa - sbs - $signed(c66);
      end
      res.s = r[63:0] & mask;
      res.o = (sr > maxv) || (sr < minv);
      return res;
   endfunction

   task automatic sample();
      gv[0] = if64.out_valid; gir[0] = if64.in_ready; gs[0] = if64.sum;          gc[0] = if64.cout; go[0] = if64.ovf;
      gv[1] = if8.out_valid;  gir[1] = if8.in_ready;  gs[1] = {56'd0, if8.sum};  gc[1] = if8.cout;  go[1] = if8.ovf;
      gv[2] = if32.out_valid; gir[2] = if32.in_ready; gs[2] = {32'd0, if32.sum}; gc[2] = if32.cout; go[2] = if32.ovf;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // One clock: settle, score handshakes that the next edge will perform, advance.
   task automatic step();
      res_t got_r, exp_r;
      #1;
      sample();
      for (int unsigned d = 0; d < NDUT; d++) begin
         got_r = '{s: gs[d], c: gc[d], o: go[d]};
         if (rst) begin
            hold[d] = 1'b0;
            continue;
         end
         if (hold[d]) begin
            checks++;
            if (!gv[d] || got_r != held[d]) begin
               failures++;
               $display("FAIL hold_stable dut%0d got v=%0b %h/%0b/%0b want v=1 %h/%0b/%0b",
                        d, gv[d], got_r.s, got_r.c, got_r.o, held[d].s, held[d].c, held[d].o);
            end
         end
         if (gv[d] && d_or) begin
            checks++;
            emit[d]++;
            if (sb[d].size() == 0) begin
               failures++;
               $display("FAIL spurious_output dut%0d got sum=%h want no result", d, got_r.s);
            end else begin
               exp_r = sb[d].pop_front();
               if (got_r != exp_r) begin
                  failures++;
                  $display("FAIL result dut%0d got %h/%0b/%0b want %h/%0b/%0b",
                           d, got_r.s, got_r.c, got_r.o, exp_r.s, exp_r.c, exp_r.o);
               end
            end
         end
         hold[d] = gv[d] && !d_or;
         if (hold[d]) held[d] = got_r;
         if (d_iv && gir[d]) begin
            acc[d]++;
            sb[d].push_back(model(WID[d], d_a, d_b, d_cin, d_sub));
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input int unsigned ncyc);
      rst = 1'b1;
      repeat (ncyc) step();
      rst = 1'b0;
      for (int unsigned d = 0; d < NDUT; d++) begin
         sb[d].delete();
         hold[d] = 1'b0;
      end
   endtask

   task automatic check_reset_state();
      #1;
      sample();
      for (int unsigned d = 0; d < NDUT; d++) begin
         check($sformatf("reset_outputs_dut%0d", d), {61'd0, gv[d], gc[d], go[d]} | gs[d], 64'd0);
         check($sformatf("reset_in_ready_dut%0d", d), {63'd0, gir[d]}, 64'd1);
      end
   endtask

   task automatic rand_ops();
      d_a   = {$urandom, $urandom};
      d_b   = {$urandom, $urandom};
      d_cin = 1'($urandom_range(0, 1));
      d_sub = 1'($urandom_range(0, 1));
   endtask

   vec_t tbl [10];
   int   lat, a0, e0, cyc;
   int   e_snap [NDUT];

   initial begin
      tbl[0] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
      tbl[1] = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      tbl[2] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
      tbl[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      tbl[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
      tbl[6] = '{64'hA, 64'h3, 1'b1, 1'b1, 64'h6, 1'b1, 1'b0};
      tbl[7] = '{64'h1, 64'h2, 1'b1, 1'b0, 64'h4, 1'b0, 1'b0};
      tbl[8] = '{64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};
      tbl[9] = '{64'h0, 64'h0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

      for (int unsigned d = 0; d < NDUT; d++) begin
         acc[d] = 0; emit[d] = 0; hold[d] = 1'b0;
      end
      d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0; d_iv = 1'b0; d_or = 1'b0;

      do_reset(2);
      check_reset_state();

      // Directed vectors on the 64/4 instance with latency measurement.
      d_or = 1'b1;
      for (int unsigned i = 0; i < 10; i++) begin
         d_a = tbl[i].a; d_b = tbl[i].b; d_cin = tbl[i].cin; d_sub = tbl[i].sub;
         d_iv = 1'b1;
         step();
         d_iv = 1'b0;
         lat = 1;
         while (!if64.out_valid && lat < 16) begin
            step();
            lat++;
         end
         check($sformatf("latency_v%0d", i), 64'(lat), 64'd4);
         check($sformatf("sum_v%0d", i), if64.sum, tbl[i].sum);
         check($sformatf("flags_v%0d", i), {62'd0, if64.cout, if64.ovf}, {62'd0, tbl[i].cout, tbl[i].ovf});
      end
      repeat (10) step();

      // Back-to-back stream: one accept and one result per cycle.
      a0 = acc[0]; e0 = emit[0];
      d_iv = 1'b1; d_or = 1'b1;
      for (int unsigned i = 0; i < 100; i++) begin
         rand_ops();
         step();
      end
      check("stream_accepts", 64'(acc[0] - a0), 64'd100);
      d_iv = 1'b0;
      repeat (4) step();
      check("stream_results", 64'(emit[0] - e0), 64'd100);

      // Fill and stall, then release.
      a0 = acc[0];
      d_iv = 1'b1; d_or = 1'b0;
      for (int unsigned i = 0; i < 10; i++) begin
         rand_ops();
         step();
      end
      check("stall_accepts", 64'(acc[0] - a0), 64'd4);
      check("stall_in_ready", {63'd0, if64.in_ready}, 64'd0);
      d_or = 1'b1;
      #1;
      check("release_in_ready", {63'd0, if64.in_ready}, 64'd1);
      e0 = emit[0];
      d_iv = 1'b0;
      repeat (12) step();
      check("release_drain", 64'(emit[0] - e0), 64'd4);

      // Random valid/ready toggling.
      a0 = acc[0]; cyc = 0;
      while ((acc[0] - a0) < 1000 && cyc < 20000) begin
         rand_ops();
         d_iv = 1'($urandom_range(0, 1));
         d_or = 1'($urandom_range(0, 1));
         step();
         cyc++;
      end
      check("random_accepts", 64'(acc[0] - a0), 64'd1000);
      d_iv = 1'b0; d_or = 1'b1;
      repeat (12) step();
      for (int unsigned d = 0; d < NDUT; d++)
         check($sformatf("random_drained_dut%0d", d), 64'(sb[d].size()), 64'd0);

      // Reset with transactions in flight and a simultaneous input offer.
      d_iv = 1'b1; d_or = 1'b1;
      repeat (3) begin
         rand_ops();
         step();
      end
      d_or = 1'b0;
      rand_ops();
      do_reset(1);
      d_iv = 1'b0;
      check_reset_state();
      for (int unsigned d = 0; d < NDUT; d++) e_snap[d] = emit[d];
      d_or = 1'b1;
      repeat (12) step();
      for (int unsigned d = 0; d < NDUT; d++)
         check($sformatf("flushed_dut%0d", d), 64'(emit[d] - e_snap[d]), 64'd0);

      // Recovery after reset.
      d_iv = 1'b1;
      repeat (20) begin
         rand_ops();
         step();
      end
      d_iv = 1'b0;
      repeat (12) step();
      for (int unsigned d = 0; d < NDUT; d++)
         check($sformatf("recover_drained_dut%0d", d), 64'(sb[d].size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor with carry-in, carry-out and signed-overflow flag, wrapped in a valid/ready stream handshake. It splits a WIDTH-bit ripple-carry add into STAGES registered slices of full_adder cells, giving one result per clock at any width. It sits in the datapath as the general add/sub unit feeding accumulators and address generators.

## Interface
- WIDTH, 64: operand and result width; must be a multiple of STAGES.
- STAGES, 4: number of pipeline slices. Also the latency in cycles. Range 1..WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in in add mode; borrow-in in sub mode.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of the MSB.
- ovf  out  1  signed overflow.

## Operation
- Transfers occur only when valid and ready are both high on the same edge, at both the input and the output.
- Add mode: {cout,sum} = a + b + cin.
- Sub mode: {cout,sum} = a + ~b + ~cin, which is a − b − cin.
  - In sub mode, borrow-out = ~cout.
  - This lets 2·WIDTH operations chain low word into high word through cout→cin (inverted for borrow).
- ovf = carry into the MSB XOR carry out of the MSB. The value is the same as if the whole operation were computed unpipelined.
- Slicing:
  - SLICE = WIDTH/STAGES.
  - Stage k adds bits [k·SLICE +: SLICE] using the carry registered from stage k−1.
  - Stage 0 uses the effective carry-in: cin, or ~cin in sub mode.
  - The b inversion is applied once, at stage 0 capture.
- Skew registers:
  - Not-yet-added upper operand slices travel forward with their stage.
  - Completed lower sum slices travel forward with their stage.
  - Slices line up at the output register.
- Each stage k has a valid bit v[k] and an advance condition adv[k] = !v[k] || adv[k+1].
  - adv[STAGES] = out_ready.
  - in_ready = adv[0]. It is combinational from out_ready and the valid bits.
- A stalled stage holds all its data, carry and valid bits unchanged.
- Bubbles collapse: an empty stage accepts from upstream even while downstream is stalled.
- Results are never dropped, duplicated or reordered.
- The mode bit travels with each transaction, so add and sub may be freely interleaved back-to-back.

## Timing
- Latency is exactly STAGES cycles from input handshake to out_valid, with no stall.
- Throughput is one transaction per cycle while out_ready = 1.
- Reset values:
  - All v[k] = 0, out_valid = 0.
  - sum = 0, cout = 0, ovf = 0. Data registers are cleared too.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-operation flushes every in-flight transaction, with no output handshake for any of them.
- rst has priority over a simultaneous in_valid/in_ready handshake; that input is discarded.
- With a full pipeline and out_ready = 0:
  - in_ready = 0.
  - On the edge where out_ready rises, the output handshakes and every stage shifts.
  - in_ready = 1 in that same cycle, so there is no bubble.
- out_valid may be held with stable data indefinitely. sum, cout and ovf are stable while out_valid && !out_ready.
- Wrap-around is modulo 2^WIDTH.
  - 0xFFFF_FFFF_FFFF_FFFF + 1 gives sum = 0, cout = 1, ovf = 0.
- STAGES = 1 degenerates to a single registered full-width add.

## Structure
- Package adder_pkg holds:
  - the add/sub mode encoding constants (MODE_ADD = 0, MODE_SUB = 1);
  - a function computing SLICE from WIDTH and STAGES;
  - a compile-time check that WIDTH % STAGES == 0.
- Sub-module adder_slice:
  - Parametrised SLICE-bit combinational ripple chain built from the existing full_adder cell.
  - Outputs: sum slice, carry-out, and carry into its MSB (used for ovf in the top slice).
  - One instance per stage, created with a generate loop.
- The top level holds the valid/advance chain, the skew registers and the output register.

## Test plan
- WIDTH=64, STAGES=4, add: a=0x0000_0000_FFFF_FFFF, b=1, cin=0 -> 4 cycles later sum=0x0000_0001_0000_0000, cout=0, ovf=0. This checks carry crossing a slice boundary.
- Sub: a=5, b=7, cin=0 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0 (borrow), ovf=0. Then a=0x8000_0000_0000_0000, b=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
- Back-to-back stream of 100 random add/sub transactions with out_ready=1 -> one result per cycle, in order, all matching the reference model a±b±cin.
- Fill the pipeline, then hold out_ready=0 for 10 cycles -> in_ready=0 after 4 accepted transactions; outputs stable; releasing out_ready drains all 4 in order with no loss.
- Random out_ready and in_valid toggling (50% each), 1000 transactions -> scoreboard matches exactly with no drop or duplicate.
- Assert rst for 1 cycle with 3 transactions in flight -> out_valid=0 next cycle, all outputs 0, no stale result ever emitted. Repeat at WIDTH=8, STAGES=1 and WIDTH=32, STAGES=8.
